// File: rtl/conv_addr_sequencer.sv
// conv_addr_sequencer: walks weight offsets for the IA address array and tracks its result latency
module conv_addr_sequencer #(
  parameter int WT_ROW_BITS  = 5,
  parameter int WT_COL_BITS  = 5,
  parameter int KER_BITS     = 5,
  parameter int CONCAT_BITS  = 8,
  parameter int CALC_LATENCY = 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [WT_ROW_BITS-1:0] i_cfg_ker_rows,
  input  logic [WT_COL_BITS-1:0] i_cfg_ker_cols,
  input  logic [KER_BITS-1:0]    i_cfg_num_ker,
  input  logic [CONCAT_BITS-1:0] i_cfg_concat_base,
  output logic [WT_ROW_BITS-1:0] o_wt_row,
  output logic [WT_COL_BITS-1:0] o_wt_col,
  output logic [KER_BITS-1:0]    o_wt_kr,
  output logic [CONCAT_BITS-1:0] o_concat_no,
  output logic                   o_issue_valid,
  input  logic                   i_issue_ready,
  output logic                   o_issue_last,
  output logic                   o_result_valid,
  output logic                   o_result_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_cfg_err
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t                   r_state, w_next;
  logic [WT_ROW_BITS-1:0]   r_rows, r_row;
  logic [WT_COL_BITS-1:0]   r_cols, r_col;
  logic [KER_BITS-1:0]      r_nk, r_kr;
  logic [CONCAT_BITS-1:0]   r_concat;
  logic                     r_err;
  logic [CALC_LATENCY-1:0]  r_vsh, r_lsh;
  logic                     w_zero, w_hs, w_col_end, w_row_end, w_kr_end;
  assign w_zero         = (i_cfg_ker_rows == '0) | (i_cfg_ker_cols == '0) | (i_cfg_num_ker == '0);
  assign w_col_end      = r_col == r_cols - WT_COL_BITS'(1);
  assign w_row_end      = r_row == r_rows - WT_ROW_BITS'(1);
  assign w_kr_end       = r_kr == r_nk - KER_BITS'(1);
  assign o_issue_valid  = r_state == S_RUN;
  assign o_issue_last   = o_issue_valid & w_col_end & w_row_end & w_kr_end;
  assign w_hs           = o_issue_valid & i_issue_ready;
  assign o_result_valid = r_vsh[CALC_LATENCY-1];
  assign o_result_last  = r_lsh[CALC_LATENCY-1];
  assign o_busy         = r_state != S_IDLE;
  assign o_done         = r_state == S_DONE;
  assign o_cfg_err      = o_done & r_err;
  assign o_wt_row       = r_row;
  assign o_wt_col       = r_col;
  assign o_wt_kr        = r_kr;
  assign o_concat_no    = r_concat;
  // next state: zero-dimension layers skip straight to DONE, DRAIN waits for the final result
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = w_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_hs && o_issue_last) w_next = S_DRAIN;
      S_DRAIN: if (o_result_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // state, latched layer config and the column/row/kernel offset counters
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_rows   <= '0;
      r_cols   <= '0;
      r_nk     <= '0;
      r_concat <= '0;
      r_err    <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_kr     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_rows   <= i_cfg_ker_rows;
        r_cols   <= i_cfg_ker_cols;
        r_nk     <= i_cfg_num_ker;
        r_concat <= i_cfg_concat_base;
        r_err    <= w_zero;
        r_row    <= '0;
        r_col    <= '0;
        r_kr     <= '0;
      end else if (w_hs) begin
        r_col <= w_col_end ? '0 : r_col + WT_COL_BITS'(1);
        if (w_col_end) r_row <= w_row_end ? '0 : r_row + WT_ROW_BITS'(1);
        if (w_col_end && w_row_end) r_kr <= w_kr_end ? '0 : r_kr + KER_BITS'(1);
      end
    end
  end
  // accepted issues travel alongside the array pipeline so results line up with their issue
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vsh <= '0;
      r_lsh <= '0;
    end else begin
      r_vsh[0] <= w_hs;
      r_lsh[0] <= w_hs & o_issue_last;
      for (int i = 1; i < CALC_LATENCY; i++) begin
        r_vsh[i] <= r_vsh[i-1];
        r_lsh[i] <= r_lsh[i-1];
      end
    end
  end
endmodule

// File: doc/conv_addr_sequencer.md
# conv_addr_sequencer

Controller that sequences the per-lane IA address-calculation array for one convolution layer. It walks every weight offset (column innermost, then row, then kernel) and presents `wt_row`, `wt_col`, `wt_kr` and `concat_no` to the array's shared broadcast inputs under a valid/ready handshake. It tracks the array's fixed pipeline latency so downstream fetch logic knows which cycles carry valid `new_ia_*` results. It also reports layer start, busy and completion to the layer scheduler.

## Interface
- `WT_ROW_BITS`, 5: width of weight row offset
- `WT_COL_BITS`, 5: width of weight column offset
- `KER_BITS`, 5: width of kernel index
- `CONCAT_BITS`, 8: width of concat number
- `CALC_LATENCY`, 1: register stages in the address array, ≥1
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  one-cycle layer start, sampled in IDLE only
- `cfg_ker_rows`  in  WT_ROW_BITS  kernel height (count, not max index)
- `cfg_ker_cols`  in  WT_COL_BITS  kernel width
- `cfg_num_ker`  in  KER_BITS  kernels per layer
- `cfg_concat_base`  in  CONCAT_BITS  concat number for this layer
- `wt_row`  out  WT_ROW_BITS  row offset to array
- `wt_col`  out  WT_COL_BITS  column offset to array
- `wt_kr`  out  KER_BITS  kernel index to array
- `concat_no`  out  CONCAT_BITS  latched `cfg_concat_base`
- `issue_valid`  out  1  offsets on `wt_*` are a live issue
- `issue_ready`  in  1  downstream accepts the current issue
- `issue_last`  out  1  current issue is the final offset of the layer
- `result_valid`  out  1  array outputs this cycle belong to an accepted issue
- `result_last`  out  1  `result_valid` for the final issue
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `cfg_err`  out  1  pulses with `done` when the layer had a zero dimension

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: when `start`=1, latch all `cfg_*`.
  - If any of rows, cols or num_ker is 0, go to DONE with the error flag set.
  - Otherwise clear the counters and go to RUN.
- RUN:
  - `issue_valid`=1.
  - A handshake is `issue_valid & issue_ready`. On each handshake, `wt_col` increments.
  - At `cols-1`, `wt_col` wraps to 0 and `wt_row` increments. At `rows-1`, `wt_row` wraps to 0 and `wt_kr` increments.
  - `issue_last` = (col==cols-1) & (row==rows-1) & (kr==nk-1), combinational on the counters.
  - A handshake with `issue_last`=1 moves the FSM to DRAIN.
- Stall: when `issue_ready`=0, the `wt_*` outputs hold stable. The array recomputes on the same inputs, which is harmless because no result is marked valid.
- Result tracking: shift register of depth CALC_LATENCY.
  - Input of the shift register: handshake, with the `issue_last` tag.
  - It advances every cycle, independent of ready.
  - Its head drives `result_valid` and `result_last`.
- DRAIN: wait until `result_last` has been emitted, then go to DONE.
- DONE:
  - `done`=1 for one cycle.
  - `cfg_err`=1 only on the zero-dimension path.
  - Next state is IDLE.
- `start` outside IDLE is ignored. Config changes after start are ignored.
- Total issues per layer: N = rows × cols × num_ker, maximum 31³. No counter overflows, because every counter wraps at its latched count.
- `concat_no` holds `cfg_concat_base` for the whole layer. The array itself adds `wt_kr`.

## Timing
- Reset values:
  - State IDLE.
  - `wt_row`, `wt_col`, `wt_kr`, `concat_no` = 0.
  - `issue_valid`, `issue_last`, `result_valid`, `result_last`, `busy`, `done`, `cfg_err` = 0.
  - Result shift register cleared.
- `start` at cycle 0: `busy`=1 from cycle 1. First issue (0,0,0) is valid at cycle 1.
- No stalls: issues occupy cycles 1..N. Results appear at cycles 1+CALC_LATENCY..N+CALC_LATENCY. `done` is high at cycle N+CALC_LATENCY+1. `busy` falls in the cycle after `done`.
- Each stalled cycle delays all later events by exactly one cycle.
- Zero-dimension start at cycle 0: `done` and `cfg_err` are high at cycle 1, with no issue and no result.
- `reset` has priority over everything, including mid-RUN and mid-DRAIN. In-flight result valids are discarded and no `done` is produced.
- `start` in the cycle `done` is high is ignored. A new layer may start in the first IDLE cycle.
- `issue_valid` never deasserts in RUN until the last handshake. `issue_ready` may toggle freely.

## Test plan
- Kernel rows=3, cols=3, nk=2, ready always 1, start at cycle 0 → 18 issues in cycles 1–18.
  - Order is (r,c) = (0,0),(0,1),(0,2),(1,0)… within each kr.
  - `issue_last` only at cycle 18 with (2,2,1). `result_last` at 19. `done` at 20.
- Same config, `issue_ready` low on every odd cycle → `wt_*` held during each low cycle.
  - Exactly 18 `result_valid` pulses in the correct order.
  - `done` delayed by the number of stall cycles.
- rows=1, cols=1, nk=1 → single issue at cycle 1 with `issue_last`=1, `result_valid`+`result_last` at cycle 2, `done` at cycle 3.
- cols=0 → `done` and `cfg_err` at cycle 1. `issue_valid` and `result_valid` never assert.
- `reset` asserted during RUN after 5 issues → next cycle all outputs at reset values, no `done`. A fresh start then begins again at (0,0,0).
- `start` pulsed while busy, and `cfg_*` changed mid-layer → no effect on sequence or count. `concat_no` stays at the originally latched base, e.g. 0x20.
